// File: rtl/ntt_twiddle_fetch.sv
// ntt_twiddle_fetch: streams twiddles from the table RAM in Cooley-Tukey stage order to the butterfly unit.
// Optional INTT_MODE_EN adds an inv input that selects omega^-k addresses for the inverse transform.
module ntt_twiddle_fetch #(
  parameter int N_LOG2 = 6,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
`ifdef INTT_MODE_EN
  input  logic              inv,
`endif
  input  logic              start,
  input  logic [3:0]        len,
  output logic              tbl_rd_en,
  output logic [N_LOG2-1:0] tbl_addr,
  input  logic [DATA_W-1:0] tbl_rdata,
  output logic [DATA_W-1:0] tw_data,
  output logic [3:0]        tw_stage,
  output logic [N_LOG2-2:0] tw_idx,
  output logic              tw_valid,
  input  logic              tw_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, RD, WT, OUT, FIN} state_t;
  state_t state_q, state_d;
  logic [3:0] l_q, l_d, s_q, s_d, stg_q, stg_d, sh;
  logic [N_LOG2-2:0] j_q, j_d, idx_q, idx_d;
  logic [N_LOG2-1:0] addr_q, addr_d, k, rd_addr;
  logic [DATA_W-1:0] data_q, data_d;
  logic err_q, err_d, len_ok, j_last, accept;
  assign sh = 4'(N_LOG2 - 1) - s_q;
  assign k = N_LOG2'(j_q) << sh;
  assign j_last = j_q == ~({(N_LOG2-1){1'b1}} << s_q);
  assign len_ok = len != 4'd0 && len <= 4'(N_LOG2);
  assign accept = state_q == IDLE && start;
`ifdef INTT_MODE_EN
  logic inv_q;
  // Negation mod N maps k=0 back to address 0 on its own.
  assign rd_addr = inv_q ? N_LOG2'(0) - k : k;
  always_ff @(posedge clk or posedge rst)
    if (rst) inv_q <= 1'b0;
    else if (accept) inv_q <= inv;
`else
  assign rd_addr = k;
`endif
  always_comb begin
    state_d = state_q;
    l_d = l_q;
    s_d = s_q;
    j_d = j_q;
    err_d = err_q;
    addr_d = addr_q;
    data_d = data_q;
    stg_d = stg_q;
    idx_d = idx_q;
    case (state_q)
      IDLE: if (start) begin
        l_d = len;
        s_d = 4'd0;
        j_d = '0;
        err_d = !len_ok;
        state_d = len_ok ? RD : FIN;
      end
      RD: begin
        addr_d = rd_addr;
        state_d = WT;
      end
      WT: begin
        data_d = tbl_rdata;
        stg_d = s_q;
        idx_d = j_q;
        state_d = OUT;
      end
      OUT: if (tw_ready) begin
        state_d = (j_last && s_q == l_q - 4'd1) ? FIN : RD;
        s_d = j_last ? s_q + 4'd1 : s_q;
        j_d = j_last ? '0 : j_q + 1'b1;
      end
      FIN: begin
        err_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      l_q <= '0;
      s_q <= '0;
      j_q <= '0;
      err_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      stg_q <= '0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      l_q <= l_d;
      s_q <= s_d;
      j_q <= j_d;
      err_q <= err_d;
      addr_q <= addr_d;
      data_q <= data_d;
      stg_q <= stg_d;
      idx_q <= idx_d;
    end
  assign tbl_rd_en = state_q == RD;
  assign tbl_addr = tbl_rd_en ? rd_addr : addr_q;
  assign tw_valid = state_q == OUT;
  assign tw_data = data_q;
  assign tw_stage = stg_q;
  assign tw_idx = idx_q;
  assign busy = state_q != IDLE;
  assign done = state_q == FIN;
  assign err = done && err_q;
endmodule

// File: tb/tb_ntt_twiddle_fetch.sv
// tb_ntt_twiddle_fetch: directed vectors for ntt_twiddle_fetch against a table holding table[k]=k+100.
module tb_ntt_twiddle_fetch;
  localparam int NL = 6;
  logic clk = 0, rst, start = 0, tw_ready = 1;
  logic [3:0] len = 0;
  logic tbl_rd_en, tw_valid, busy, done, err;
  logic [NL-1:0] tbl_addr;
  logic [63:0] tbl_rdata = 0, tw_data;
  logic [3:0] tw_stage;
  logic [NL-2:0] tw_idx;
  bit inv_m = 0;
  int vectors = 0, miscompares = 0;
`ifdef INTT_MODE_EN
  logic inv = 0;
`endif

  ntt_twiddle_fetch #(.N_LOG2(NL), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
`ifdef INTT_MODE_EN
    .inv(inv),
`endif
    .start(start), .len(len), .tbl_rd_en(tbl_rd_en), .tbl_addr(tbl_addr), .tbl_rdata(tbl_rdata),
    .tw_data(tw_data), .tw_stage(tw_stage), .tw_idx(tw_idx), .tw_valid(tw_valid), .tw_ready(tw_ready),
    .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;
  always @(posedge clk) tbl_rdata <= tbl_rd_en ? 64'(tbl_addr) + 64'd100 : 64'hBAD0BAD0;

  typedef struct {
    logic [3:0] len;
    int n, ls, lj;
    logic [63:0] ld;
    logic e;
  } vec_t;
  vec_t vt[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] twv(input int s, input int j);
    int k = (j << (NL - 1 - s)) & 63;
    if (inv_m) k = (64 - k) % 64;
    return 64'(k + 100);
  endfunction

  task automatic run(input logic [3:0] l, input int n, input int ls, input int lj, input logic [63:0] ld, input logic e);
    int hs = 0, rds = 0, fv = -1, dc = -1, hc = -1, es = 0, ej = 0, gs = -1, gj = -1;
    logic [63:0] gd = 0;
    @(negedge clk);
    start = 1;
    len = l;
    @(negedge clk);
    start = 0;
    len = 4'd3;
    for (int c = 1; c < 1000 && dc < 0; c++) begin
      if (c > 1) @(negedge clk);
      if (tbl_rd_en) rds++;
      if (tw_valid && fv < 0) fv = c;
      if (tw_valid && tw_ready) begin
        chk("tw_stage", 64'(tw_stage), 64'(es));
        chk("tw_idx", 64'(tw_idx), 64'(ej));
        chk("tw_data", tw_data, twv(es, ej));
        gs = int'(tw_stage);
        gj = int'(tw_idx);
        gd = tw_data;
        hs++;
        hc = c;
        ej++;
        if (ej == (1 << es)) begin
          es++;
          ej = 0;
        end
      end
      if (done) begin
        dc = c;
        chk("err", 64'(err), 64'(e));
      end
    end
    chk("done_seen", 64'(dc >= 0), 64'd1);
    chk("count", 64'(hs), 64'(n));
    chk("reads", 64'(rds), 64'(n));
    if (n > 0) begin
      chk("first_lat", 64'(fv), 64'd3);
      chk("last_s", 64'(gs), 64'(ls));
      chk("last_j", 64'(gj), 64'(lj));
      chk("last_d", gd, ld);
      chk("done_lat", 64'(dc), 64'(hc + 1));
    end else begin
      chk("no_valid", 64'(fv), -64'sd1);
      chk("err_lat", 64'(dc), 64'd1);
    end
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [63:0] d2;
    logic [8:0] si2;
    int rds, hs, nd;
    vt[0] = '{4'd1, 1, 0, 0, 64'd100, 1'b0};
    vt[1] = '{4'd2, 3, 1, 1, 64'd116, 1'b0};
    vt[2] = '{4'd3, 7, 2, 3, 64'd124, 1'b0};
    vt[3] = '{4'd4, 15, 3, 7, 64'd128, 1'b0};
    vt[4] = '{4'd5, 31, 4, 15, 64'd130, 1'b0};
    vt[5] = '{4'd6, 63, 5, 31, 64'd131, 1'b0};
    vt[6] = '{4'd0, 0, 0, 0, 64'd0, 1'b1};
    vt[7] = '{4'd7, 0, 0, 0, 64'd0, 1'b1};
    vt[8] = '{4'd15, 0, 0, 0, 64'd0, 1'b1};
    rst = 1;
    #2;
    chk("reset_out", 64'({tbl_rd_en, tbl_addr, tw_valid, tw_stage, tw_idx, busy, done, err}), 64'd0);
    chk("reset_data", tw_data, 64'd0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 9; i++) run(vt[i].len, vt[i].n, vt[i].ls, vt[i].lj, vt[i].ld, vt[i].e);
`ifdef INTT_MODE_EN
    inv = 1;
    inv_m = 1;
    run(4'd2, 3, 1, 1, 64'd148, 1'b0);
    inv = 0;
    inv_m = 0;
`endif
    // backpressure on the second twiddle, with a start pulse that must be ignored
    tw_ready = 0;
    @(negedge clk);
    start = 1;
    len = 4'd2;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 10 && !tw_valid; i++) @(negedge clk);
    chk("bp_v1", 64'(tw_valid), 64'd1);
    tw_ready = 1;
    @(negedge clk);
    tw_ready = 0;
    for (int i = 0; i < 10 && !tw_valid; i++) @(negedge clk);
    chk("bp_v2", 64'(tw_valid), 64'd1);
    chk("bp_d2", tw_data, 64'd100);
    chk("bp_si2", 64'({tw_stage, tw_idx}), 64'({4'd1, 5'd0}));
    d2 = tw_data;
    si2 = {tw_stage, tw_idx};
    start = 1;
    len = 4'd0;
    rds = 0;
    repeat (5) begin
      @(negedge clk);
      if (tbl_rd_en) rds++;
      chk("bp_hold_v", 64'(tw_valid), 64'd1);
      chk("bp_hold_d", tw_data, d2);
      chk("bp_hold_si", 64'({tw_stage, tw_idx}), 64'(si2));
    end
    start = 0;
    chk("bp_no_read", 64'(rds), 64'd0);
    tw_ready = 1;
    @(negedge clk);
    for (int i = 0; i < 10 && !tw_valid; i++) @(negedge clk);
    chk("bp_d3", tw_data, 64'd116);
    chk("bp_si3", 64'({tw_stage, tw_idx}), 64'({4'd1, 5'd1}));
    @(negedge clk);
    chk("bp_done", 64'({done, err}), 64'b10);
    @(negedge clk);
    chk("bp_busy", 64'(busy), 64'd0);
    // reset mid-run after the 10th handshake
    @(negedge clk);
    start = 1;
    len = 4'd6;
    @(negedge clk);
    start = 0;
    hs = 0;
    for (int c = 0; c < 200 && hs < 10; c++) begin
      if (tw_valid && tw_ready) hs++;
      if (hs < 10) @(negedge clk);
    end
    chk("rst_hs", 64'(hs), 64'd10);
    @(posedge clk);
    #1 rst = 1;
    #1;
    chk("rst_mid_out", 64'({tbl_rd_en, tbl_addr, tw_valid, tw_stage, tw_idx, busy, done, err}), 64'd0);
    chk("rst_mid_data", tw_data, 64'd0);
    @(negedge clk);
    rst = 0;
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("rst_no_done", 64'(nd), 64'd0);
    run(4'd1, 1, 0, 0, 64'd100, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
